etx_packet_arbiter: RTL and testbench

- Shares the single eLink TX emesh packet channel among N requesters: AXI-slave write path, AXI-slave read-request path, and the mailbox/config read-response path.
- Round-robin arbitration with per-requester burst lock, bounded by a maximum burst length.
- One-cycle registered output stage with wait (backpressure) propagation.
- Sits between the AXI/emesh bridge logic and the eLink transmitter packet input, clocked in the TX core clock domain.

---
 rtl/etx_packet_arbiter_pkg.sv | 18 +
 rtl/etx_rr_select.sv | 25 ++
 rtl/etx_packet_arbiter.sv | 117 +++++++++++
 tb/tb_etx_packet_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/etx_packet_arbiter_pkg.sv
// Shared emesh definitions for the eLink TX packet arbiter: packet width,
// packet field offsets and the arbiter grant type.
package etx_packet_arbiter_pkg;

  localparam int EMESH_PW = 104;

  localparam int EMESH_WRITE_LSB    = 0;
  localparam int EMESH_DATAMODE_LSB = 1;
  localparam int EMESH_CTRLMODE_LSB = 3;
  localparam int EMESH_DSTADDR_LSB  = 8;
  localparam int EMESH_DATA_LSB     = 40;
  localparam int EMESH_SRCADDR_LSB  = 72;

  localparam int ARB_N = 3;

  typedef logic [ARB_N-1:0] arb_grant_t;

endpackage

// File: rtl/etx_rr_select.sv
// Round-robin search: rotate requests down by the pointer, keep the lowest
// set bit, and rotate the one-hot result back to requester numbering.
module etx_rr_select
  import etx_packet_arbiter_pkg::*;
#(
  parameter int N    = ARB_N,
  parameter int PTRW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PTRW-1:0] ptr,
  output logic [N-1:0]    sel
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] rot;
  logic [N-1:0] pe;

  always_comb begin
    rot = N'({req, req} >> ptr);
    pe  = rot & (~rot + ONE);
    sel = N'(({pe, pe} << ptr) >> N);
  end

endmodule

// File: rtl/etx_packet_arbiter.sv
// Shares the eLink TX emesh packet channel among N requesters with round-robin
// arbitration, bounded burst lock and a single registered output stage.
module etx_packet_arbiter
  import etx_packet_arbiter_pkg::*;
#(
  parameter int PW       = EMESH_PW,
  parameter int N        = ARB_N,
  parameter int MAXBURST = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    access_in,
  input  logic [N*PW-1:0] packet_in,
  input  logic [N-1:0]    lock_in,
  output logic [N-1:0]    wait_out,
  output logic            access_out,
  output logic [PW-1:0]   packet_out,
  input  logic            wait_in,
  output logic [N-1:0]    grant_out
);

  localparam int PTRW = $clog2(N);
  localparam int CNTW = (MAXBURST > 1) ? $clog2(MAXBURST) : 1;
  localparam logic [N-1:0]    ONE      = N'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MAXBURST - 1);

  function automatic logic [PTRW-1:0] wrap_inc(input logic [PTRW-1:0] idx);
    wrap_inc = (idx == PTRW'(N - 1)) ? '0 : idx + PTRW'(1);
  endfunction

  function automatic logic [PTRW-1:0] onehot_idx(input logic [N-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < N; i++)
      if (oh[i]) onehot_idx = PTRW'(i);
  endfunction

  logic [PTRW-1:0] ptr_q;
  logic [PTRW-1:0] owner_q;
  logic            lock_q;
  logic [CNTW-1:0] burst_cnt;

  logic            load;
  logic            burst_done;
  logic            locked;
  logic            any_req;
  logic            sel_lock;
  logic            continue_burst;
  logic [PTRW-1:0] sel_ptr;
  logic [PTRW-1:0] sel_idx;
  logic [N-1:0]    owner_oh;
  logic [N-1:0]    rr_sel;
  logic [N-1:0]    sel;
  logic [PW-1:0]   sel_pkt;

  // A burst that has used its allowance searches from just past the owner,
  // so any other pending requester wins before the owner is served again.
  always_comb begin
    load       = ~access_out | ~wait_in;
    burst_done = lock_q & (burst_cnt >= CNT_LAST);
    locked     = lock_q & ~burst_done;
    sel_ptr    = burst_done ? wrap_inc(owner_q) : ptr_q;
    owner_oh   = ONE << owner_q;
    any_req    = |access_in;
  end

  etx_rr_select #(
    .N    (N),
    .PTRW (PTRW)
  ) u_rr_select (
    .req (access_in),
    .ptr (sel_ptr),
    .sel (rr_sel)
  );

  always_comb begin
    sel            = (locked && (access_in & owner_oh) != '0) ? owner_oh : rr_sel;
    sel_idx        = onehot_idx(sel);
    sel_lock       = |(lock_in & sel);
    continue_burst = locked & (sel == owner_oh);
    sel_pkt        = '0;
    for (int i = 0; i < N; i++)
      if (sel[i]) sel_pkt = packet_in[i*PW +: PW];
    wait_out = access_in & ~({N{load}} & sel);
  end

  // p0 -> p1: accept into the output register and update the arbitration state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      access_out <= 1'b0;
      packet_out <= '0;
      grant_out  <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      burst_cnt  <= '0;
    end else if (load) begin
      if (any_req) begin
        access_out <= 1'b1;
        packet_out <= sel_pkt;
        grant_out  <= sel;
        owner_q    <= sel_idx;
        lock_q     <= sel_lock;
        if (sel_lock) begin
          ptr_q     <= sel_idx;
          burst_cnt <= (continue_burst && burst_cnt < CNT_LAST) ? burst_cnt + CNTW'(1) : '0;
        end else begin
          ptr_q     <= wrap_inc(sel_idx);
          burst_cnt <= '0;
        end
      end else begin
        access_out <= 1'b0;
        grant_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_etx_packet_arbiter.sv
// Directed bench for etx_packet_arbiter: a vector table for the basic
// arbitration, stall and reset cases, plus hand-written burst sequences.
module tb_etx_packet_arbiter;

  localparam int PW = 104;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    access_in;
  logic [N*PW-1:0] packet_in;
  logic [N-1:0]    lock_in;
  logic            wait_in;

  logic [N-1:0]  wait_out, wait_out4;
  logic          access_out, access_out4;
  logic [PW-1:0] packet_out, packet_out4;
  logic [N-1:0]  grant_out, grant_out4;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  etx_packet_arbiter #(.PW(PW), .N(N), .MAXBURST(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .access_in  (access_in),
    .packet_in  (packet_in),
    .lock_in    (lock_in),
    .wait_out   (wait_out),
    .access_out (access_out),
    .packet_out (packet_out),
    .wait_in    (wait_in),
    .grant_out  (grant_out)
  );

  etx_packet_arbiter #(.PW(PW), .N(N), .MAXBURST(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .access_in  (access_in),
    .packet_in  (packet_in),
    .lock_in    (lock_in),
    .wait_out   (wait_out4),
    .access_out (access_out4),
    .packet_out (packet_out4),
    .wait_in    (wait_in),
    .grant_out  (grant_out4)
  );

  typedef struct {
    logic       rst;
    logic [2:0] acc;
    logic [2:0] lck;
    logic       win;
    int         gen;
    logic [2:0] exp_wait;
    logic       exp_acc;
    logic [2:0] exp_gnt;
    int         exp_req;
    int         exp_gen;
  } vec_t;

  vec_t vecs[16];

  // Requester req's packet for generation gen; req < 0 stands for all zeros.
  function automatic logic [PW-1:0] mk(input int req, input int gen);
    if (req < 0) return '0;
    return {8'(gen), 8'(req + 1), 88'hC0FF_EE00_0012_3456_7890_AB};
  endfunction

  function automatic vec_t v(input logic rst, input logic [2:0] acc, input logic [2:0] lck,
                             input logic win, input int gen, input logic [2:0] exp_wait,
                             input logic exp_acc, input logic [2:0] exp_gnt,
                             input int exp_req, input int exp_gen);
    vec_t r;
    r.rst = rst; r.acc = acc; r.lck = lck; r.win = win; r.gen = gen;
    r.exp_wait = exp_wait; r.exp_acc = exp_acc; r.exp_gnt = exp_gnt;
    r.exp_req = exp_req; r.exp_gen = exp_gen;
    return r;
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, input logic [2:0] acc, input logic [2:0] lck,
                       input logic win, input int gen);
    reset     = rst;
    access_in = acc;
    lock_in   = lck;
    wait_in   = win;
    for (int i = 0; i < N; i++) packet_in[i*PW +: PW] = mk(i, gen);
  endtask

  task automatic do_reset();
    apply(1'b1, 3'b000, 3'b000, 1'b0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp4[6];

    //               rst  acc     lck     win  gen  wait    acc   gnt    req gen
    vecs[0]  = v(1'b1, 3'b111, 3'b000, 1'b0, 0, 3'b110, 1'b0, 3'b000, -1, 0);
    vecs[1]  = v(1'b0, 3'b111, 3'b000, 1'b0, 1, 3'b110, 1'b1, 3'b001,  0, 1);
    vecs[2]  = v(1'b0, 3'b111, 3'b000, 1'b0, 2, 3'b101, 1'b1, 3'b010,  1, 2);
    vecs[3]  = v(1'b0, 3'b111, 3'b000, 1'b0, 3, 3'b011, 1'b1, 3'b100,  2, 3);
    vecs[4]  = v(1'b0, 3'b010, 3'b000, 1'b1, 4, 3'b010, 1'b1, 3'b100,  2, 3);
    vecs[5]  = v(1'b0, 3'b010, 3'b000, 1'b1, 4, 3'b010, 1'b1, 3'b100,  2, 3);
    vecs[6]  = v(1'b0, 3'b010, 3'b000, 1'b1, 4, 3'b010, 1'b1, 3'b100,  2, 3);
    vecs[7]  = v(1'b0, 3'b010, 3'b000, 1'b1, 4, 3'b010, 1'b1, 3'b100,  2, 3);
    vecs[8]  = v(1'b0, 3'b010, 3'b000, 1'b0, 4, 3'b000, 1'b1, 3'b010,  1, 4);
    vecs[9]  = v(1'b0, 3'b000, 3'b000, 1'b0, 5, 3'b000, 1'b0, 3'b000,  1, 4);
    vecs[10] = v(1'b0, 3'b000, 3'b000, 1'b0, 5, 3'b000, 1'b0, 3'b000,  1, 4);
    vecs[11] = v(1'b0, 3'b001, 3'b000, 1'b1, 5, 3'b000, 1'b1, 3'b001,  0, 5);
    vecs[12] = v(1'b0, 3'b110, 3'b000, 1'b1, 6, 3'b110, 1'b1, 3'b001,  0, 5);
    vecs[13] = v(1'b1, 3'b110, 3'b000, 1'b1, 6, 3'b100, 1'b0, 3'b000, -1, 0);
    vecs[14] = v(1'b0, 3'b111, 3'b000, 1'b1, 7, 3'b110, 1'b1, 3'b001,  0, 7);
    vecs[15] = v(1'b0, 3'b111, 3'b000, 1'b0, 8, 3'b101, 1'b1, 3'b010,  1, 8);

    apply(1'b1, 3'b000, 3'b000, 1'b0, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 16; k++) begin
      apply(vecs[k].rst, vecs[k].acc, vecs[k].lck, vecs[k].win, vecs[k].gen);
      #1;
      chk($sformatf("v%0d wait_out", k), PW'(wait_out), PW'(vecs[k].exp_wait));
      @(posedge clk); #1;
      chk($sformatf("v%0d access_out", k), PW'(access_out), PW'(vecs[k].exp_acc));
      chk($sformatf("v%0d grant_out", k), PW'(grant_out), PW'(vecs[k].exp_gnt));
      chk($sformatf("v%0d packet_out", k), packet_out, mk(vecs[k].exp_req, vecs[k].exp_gen));
    end

    // Requester 0 locks with 1 and 2 pending: MAXBURST=4 hands over after 4 grants.
    exp4[0] = 3'b001; exp4[1] = 3'b001; exp4[2] = 3'b001;
    exp4[3] = 3'b001; exp4[4] = 3'b010; exp4[5] = 3'b100;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 3'b111, 3'b001, 1'b0, 20 + k);
      @(posedge clk); #1;
      chk($sformatf("burst4 grant %0d", k), PW'(grant_out4), PW'(exp4[k]));
      chk($sformatf("burst16 grant %0d", k), PW'(grant_out), PW'(3'b001));
    end

    // Requester 2 alone and locked for 20 packets: no bubble, counter wraps after 16.
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      apply(1'b0, 3'b100, 3'b100, 1'b0, 40 + k);
      @(posedge clk); #1;
      chk($sformatf("solo access %0d", k), PW'(access_out), PW'(1'b1));
      chk($sformatf("solo grant %0d", k), PW'(grant_out), PW'(3'b100));
      chk($sformatf("solo packet %0d", k), packet_out, mk(2, 40 + k));
      chk($sformatf("solo count %0d", k), PW'(dut.burst_cnt), PW'((k - 1) % 16));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
